// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, zero-register address and flattened-port slice helper
package reg_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;
    function automatic int lo(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/reg_file_wr_select.sv
// reg_file_wr_select: priority merge of all write ports for one address
//   wr_en_i/wr_addr_i/wr_data_i: flattened write ports
//   addr_i: address being resolved; hit_o/data_o: any port writes it, winning data
module reg_file_wr_select
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);
    // ascending scan so the highest matching port index overrides the rest
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int p = 0; p < NUM_WR; p++)
            if (wr_en_i[p] && wr_addr_i[lo(p, ADDR_W) +: ADDR_W] == addr_i) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[lo(p, DATA_W) +: DATA_W];
            end
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with bypass, zero register and busy scoreboard
//   clk/reset: clock, async active-high reset
//   rd_en/rd_addr -> rd_data/rd_busy: registered read ports (1-cycle latency, hold when idle)
//   wr_en/wr_addr/wr_data: write ports, highest index wins on collisions
//   res_en/res_addr: mark a register busy; busy_vec: registered scoreboard
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     res_en,
    input  logic [ADDR_W-1:0]        res_addr,
    output logic [2**ADDR_W-1:0]     busy_vec
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DATA_W-1:0]        w_data [DEPTH];
    logic [DEPTH-1:0]         w_hit;
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [ADDR_W-1:0]        ra [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    for (genvar a = 0; a < DEPTH; a++) begin : g_addr
        localparam bit ZA = ZERO_REG != 0 && a == ZERO_ADDR;
        logic hit_raw;
        reg_file_wr_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_sel (
            .wr_en_i  (wr_en),
            .wr_addr_i(wr_addr),
            .wr_data_i(wr_data),
            .addr_i   (ADDR_W'(a)),
            .hit_o    (hit_raw),
            .data_o   (w_data[a])
        );
        // the zero register never sees a write, so it also never bypasses or clears busy
        assign w_hit[a]  = hit_raw && !ZA;
        assign mem_d[a]  = w_hit[a] ? w_data[a] : mem_q[a];
        // a same-cycle reserve supersedes the completing write
        assign busy_d[a] = (res_en && res_addr == ADDR_W'(a) && !ZA) ? 1'b1 :
                           w_hit[a] ? 1'b0 : busy_q[a];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_ra
        assign ra[i] = rd_addr[lo(i, ADDR_W) +: ADDR_W];
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int i = 0; i < NUM_RD; i++)
            if (rd_en[i]) begin
                rd_data_d[lo(i, DATA_W) +: DATA_W] = (BYPASS != 0 && w_hit[ra[i]]) ? w_data[ra[i]] : mem_q[ra[i]];
                rd_busy_d[i] = (BYPASS != 0) ? busy_d[ra[i]] : busy_q[ra[i]];
            end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            mem_q     <= '{default: '0};
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            mem_q     <= mem_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end

    assign rd_data  = rd_data_q;
    assign rd_busy  = rd_busy_q;
    assign busy_vec = busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp, bypass and read-first builds side by side
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             res_en;
    logic [AW-1:0]    res_addr;
    logic [NR*DW-1:0] rd_data1, rd_data0;
    logic [NR-1:0]    rd_busy1, rd_busy0;
    logic [DEPTH-1:0] busy_vec1, busy_vec0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .res_en(res_en), .res_addr(res_addr), .busy_vec(busy_vec1)
    );
    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1), .BYPASS(0)) u_rdf (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .res_en(res_en), .res_addr(res_addr), .busy_vec(busy_vec0)
    );

    typedef struct {
        logic [NR*DW-1:0] rd1, rd0;
        logic [NR-1:0]    rb1, rb0;
        logic [DEPTH-1:0] bv;
    } exp_t;

    exp_t sb_q[$];
    logic [DW-1:0]    m_mem [DEPTH];
    logic [DEPTH-1:0] m_busy;
    logic [NR*DW-1:0] m_rd1, m_rd0;
    logic [NR-1:0]    m_rb1, m_rb0;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        m_busy = '0;
        m_rd1 = '0;
        m_rd0 = '0;
        m_rb1 = '0;
        m_rb0 = '0;
    endtask

    task automatic idle();
        rd_en  = '0;
        wr_en  = '0;
        res_en = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_res(input logic [AW-1:0] a);
        res_en   = 1'b1;
        res_addr = a;
    endtask

    // predict the post-edge outputs of both builds, clock once, compare
    task automatic step();
        logic             hit [DEPTH];
        logic [DW-1:0]    wd [DEPTH];
        logic [DEPTH-1:0] nb;
        logic [AW-1:0]    wa, ra;
        exp_t e, g;
        for (int a = 0; a < DEPTH; a++) begin
            hit[a] = 1'b0;
            wd[a]  = '0;
        end
        for (int w = 0; w < NW; w++) begin
            wa = wr_addr[w*AW +: AW];
            if (wr_en[w] && wa != 0) begin
                hit[wa] = 1'b1;
                wd[wa]  = wr_data[w*DW +: DW];
            end
        end
        for (int a = 0; a < DEPTH; a++)
            nb[a] = (res_en && res_addr == AW'(a) && a != 0) ? 1'b1 : hit[a] ? 1'b0 : m_busy[a];
        for (int i = 0; i < NR; i++)
            if (rd_en[i]) begin
                ra = rd_addr[i*AW +: AW];
                m_rd1[i*DW +: DW] = hit[ra] ? wd[ra] : m_mem[ra];
                m_rb1[i] = nb[ra];
                m_rd0[i*DW +: DW] = m_mem[ra];
                m_rb0[i] = m_busy[ra];
            end
        for (int a = 0; a < DEPTH; a++)
            if (hit[a]) m_mem[a] = wd[a];
        m_busy = nb;
        e.rd1 = m_rd1;
        e.rd0 = m_rd0;
        e.rb1 = m_rb1;
        e.rb0 = m_rb0;
        e.bv  = m_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk("rd_data_byp", 64'(rd_data1), 64'(g.rd1));
        chk("rd_busy_byp", 64'(rd_busy1), 64'(g.rb1));
        chk("busy_vec_byp", 64'(busy_vec1), 64'(g.bv));
        chk("rd_data_rdf", 64'(rd_data0), 64'(g.rd0));
        chk("rd_busy_rdf", 64'(rd_busy0), 64'(g.rb0));
        chk("busy_vec_rdf", 64'(busy_vec0), 64'(g.bv));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_data_byp"}, 64'(rd_data1), 64'd0);
        chk({tag, "_rd_busy_byp"}, 64'(rd_busy1), 64'd0);
        chk({tag, "_busy_vec_byp"}, 64'(busy_vec1), 64'd0);
        chk({tag, "_rd_data_rdf"}, 64'(rd_data0), 64'd0);
        chk({tag, "_rd_busy_rdf"}, 64'(rd_busy0), 64'd0);
        chk({tag, "_busy_vec_rdf"}, 64'(busy_vec0), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        res_addr = '0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // reset contents read back as zero
        set_rd(0, 5'd3); set_rd(1, 5'd7); step();
        chk("read_r3_after_reset", 64'(rd_data1[31:0]), 64'd0);

        // basic write then read, then hold with rd_en low
        idle(); set_wr(0, 5'd5, 32'hDEADBEEF); step();
        idle(); step();
        set_rd(0, 5'd5); step();
        chk("read_r5", 64'(rd_data1[31:0]), 64'hDEADBEEF);
        idle(); step();
        chk("hold_r5", 64'(rd_data1[31:0]), 64'hDEADBEEF);

        // same-address write conflict
        set_wr(0, 5'd9, 32'h11111111); set_wr(1, 5'd9, 32'h22222222); step();
        idle(); set_rd(1, 5'd9); step();
        chk("conflict_r9", 64'(rd_data1[63:32]), 64'h22222222);

        // bypass vs read-first
        idle(); set_wr(0, 5'd4, 32'h0BADF00D); step();
        idle(); set_wr(1, 5'd4, 32'hCAFEF00D); set_rd(0, 5'd4); step();
        chk("bypass_r4", 64'(rd_data1[31:0]), 64'hCAFEF00D);
        chk("readfirst_r4", 64'(rd_data0[31:0]), 64'h0BADF00D);

        // zero register
        idle(); set_wr(0, 5'd0, 32'hFFFFFFFF); set_res(5'd0); set_rd(0, 5'd0); step();
        chk("zero_rd_byp", 64'(rd_data1[31:0]), 64'd0);
        chk("zero_busy", 64'(busy_vec1[0]), 64'd0);
        idle(); set_rd(1, 5'd0); step();
        chk("zero_rd_later", 64'(rd_data0[63:32]), 64'd0);

        // scoreboard
        idle(); set_res(5'd12); step();
        chk("bv12_set", 64'(busy_vec1[12]), 64'd1);
        idle(); set_wr(0, 5'd12, 32'h0C0C0C0C); set_rd(1, 5'd12); step();
        chk("bv12_clr", 64'(busy_vec1[12]), 64'd0);
        chk("rb12_post", 64'(rd_busy1[1]), 64'd0);
        chk("rb12_pre", 64'(rd_busy0[1]), 64'd1);
        idle(); set_res(5'd12); set_wr(1, 5'd12, 32'h12121212); step();
        chk("bv12_res_wins", 64'(busy_vec1[12]), 64'd1);
        idle(); set_rd(1, 5'd12); step();
        chk("r12_updated", 64'(rd_data0[63:32]), 64'h12121212);

        // random traffic on a narrow address range to force collisions
        for (int n = 0; n < 300; n++) begin
            idle();
            for (int p = 0; p < NW; p++)
                if ($urandom_range(0, 1) == 1) set_wr(p, AW'($urandom_range(0, 15)), $urandom);
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 2) != 0) set_rd(p, AW'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) set_res(AW'($urandom_range(0, 15)));
            step();
        end

        // asynchronous reset mid-cycle, with a write and reserve in flight
        idle(); set_wr(0, 5'd5, 32'hA5A5A5A5); set_res(5'd6);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        set_rd(0, 5'd5); set_rd(1, 5'd6); step();
        chk("discard_r5", 64'(rd_data1[31:0]), 64'd0);
        chk("discard_bv6", 64'(busy_vec1[6]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
